dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter: ADDR_W, 22, physical address width (matches CPU address_bus).
REQ-002 Clocking: one clock, clk; reset is arst, asynchronous and active-high.
REQ-003 Port: clk  in  1  rising-edge system clock.
REQ-004 Port: arst  in  1  async active-high reset.
REQ-005 Port: cfg_we  in  1  config register write strobe, sampled at clk.
REQ-006 Port: cfg_addr  in  3  register index.
- 0/1/2: src lo/mid/hi.
- 3/4/5: dst lo/mid/hi. Hi byte uses bits 5:0.
- 6: count.
- 7: control.
REQ-007 Port: cfg_wdata  in  8  config write data.
REQ-008 Port: dma_req  out  1  bus request to CPU.
REQ-009 Port: dma_ack  in  1  CPU grant; CPU has tristated its bus.
REQ-010 Port: ext_wait  in  1  active-high memory/IO stall.
REQ-011 Port: address_bus  out  ADDR_W  transfer address.
REQ-012 Port: mem_io  out  1  1=memory, 0=IO.
REQ-013 Port: rd_n  out  1  active-low read strobe.
REQ-014 Port: wr_n  out  1  active-low write strobe.
REQ-015 Port: data_in  in  8  read data.
REQ-016 Port: data_out  out  8  write data.
REQ-017 Port: data_oe  out  1  data_out valid, drive data bus.
REQ-018 Port: bus_en  out  1  address/strobes/mem_io driven; external tristate when 0.
REQ-019 Port: busy  out  1  transfer in progress.
REQ-020 Port: remaining  out  8  bytes left.
REQ-021 Port: done  out  1  one-cycle completion pulse.
REQ-022 Port: irq  out  1  sticky completion interrupt.

Function
REQ-023 Control bits:
- bit0 start.
- bit1 src_mem (mem_io during read).
- bit2 dst_mem (mem_io during write).
- bit3 abort.
- bit4 irq_clr.
REQ-024 In IDLE, writes to regs 0-6 update the register. While busy they are ignored.
REQ-025 FSM states: IDLE, REQ, RD, WR, DONE.
REQ-026 IDLE: a control write with start=1 enters REQ on the next clk.
- src_mem and dst_mem are latched at that write.
- count is copied to remaining.
- count 0 transfers 256 bytes.
- start while busy is ignored.
REQ-027 dma_req=1 in REQ, RD, WR. dma_req=0 in IDLE and DONE.
REQ-028 REQ: stays until dma_ack=1, then enters RD.
REQ-029 RD outputs:
- bus_en=1, rd_n=0.
- address_bus=src, mem_io=src_mem.
REQ-030 RD exit: on a cycle with ext_wait=0 and dma_ack=1, data_in is latched into an 8-bit buffer and the FSM enters WR.
REQ-031 WR outputs:
- bus_en=1, wr_n=0, data_oe=1.
- address_bus=dst, mem_io=dst_mem, data_out=buffer.
REQ-032 WR exit: on a cycle with ext_wait=0 and dma_ack=1:
- src and dst increment by 1 (ADDR_W-bit, 3FFFFF wraps to 0).
- remaining decrements by 1 (mod 256).
- If remaining was 1, the FSM enters DONE; otherwise RD.
REQ-033 rd_n and wr_n are never low in the same cycle. bus_en=0 outside RD/WR.
REQ-034 If dma_ack drops in RD/WR, the state and all counters freeze and the outputs are held until dma_ack returns.
REQ-035 Abort: a control write with abort=1 while busy is latched.
- In REQ, the FSM goes to DONE immediately.
- In RD/WR, the current WR completes and the FSM then enters DONE instead of RD.
REQ-036 DONE lasts exactly one cycle: done=1 and irq set, then IDLE.
REQ-037 busy=1 in REQ, RD, WR, DONE.
REQ-038 irq clears on a control write with irq_clr=1. If set and clear occur in the same cycle, set wins.
REQ-039 Per-byte latency with no wait: 2 clk (RD, WR). Total for N bytes from the start write: 1 + (REQ cycles) + 2N + 1.

Reset
REQ-040 arst=1 asynchronously forces:
- IDLE; dma_req=0, bus_en=0, rd_n=1, wr_n=1, data_oe=0.
- address_bus=0, data_out=0, mem_io=0.
- busy=0, done=0, irq=0, remaining=0.
- all config registers, buffer and abort latch = 0.
REQ-041 arst mid-transfer aborts the transfer without a done pulse or irq.

Verification
REQ-042 Basic copy: src=000100, dst=200000, count=3, start, src_mem=dst_mem=1, dma_ack granted 2 clk after dma_req.
- Response: 3 read/write pairs at 000100-000102 to 200000-200002.
- done pulses once; irq=1; remaining=0.
REQ-043 Wrap: src=3FFFFF, count=2.
- Response: second read address is 000000.
REQ-044 Wait and ack-drop: ext_wait=1 for 3 clk during RD, then dma_ack=0 for 2 clk during WR.
- Response: strobes, address and remaining held; data unchanged; transfer completes correctly.
REQ-045 Abort: count=0 (256 bytes), abort written during 5th RD.
- Response: 5 bytes written, then DONE; remaining=251.
REQ-046 Reset mid-transfer: arst pulsed during WR.
- Response: all outputs at reset values immediately, no done/irq.
- A subsequent start works normally.
REQ-047 irq clear on the DONE cycle: irq remains 1. A later clear sets irq=0.

Source files
------------

// File: rtl/dma_controller.sv
// Single-channel byte DMA: takes the CPU bus via dma_req/dma_ack and copies
// `count` bytes (0 = 256) from src to dst, one read/write pair per byte.
module dma_controller #(
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_addr,
   input  logic [7:0]        cfg_wdata,
   output logic              dma_req,
   input  logic              dma_ack,
   input  logic              ext_wait,
   output logic [ADDR_W-1:0] address_bus,
   output logic              mem_io,
   output logic              rd_n,
   output logic              wr_n,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              data_oe,
   output logic              bus_en,
   output logic              busy,
   output logic [7:0]        remaining,
   output logic              done,
   output logic              irq
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [7:0]        count_q, count_d, remaining_q, remaining_d, buf_q, buf_d;
   logic              src_mem_q, src_mem_d, dst_mem_q, dst_mem_d;
   logic              abort_q, abort_d, irq_q, irq_d;
   logic              ctrl_wr, step, rd_st, wr_st;

   assign ctrl_wr = cfg_we && (cfg_addr == 3'd7);
   // A bus phase only advances when the CPU still grants and nothing stalls.
   assign step    = dma_ack && !ext_wait;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      buf_d       = buf_q;
      src_mem_d   = src_mem_q;
      dst_mem_d   = dst_mem_q;
      abort_d     = abort_q;
      irq_d       = irq_q;

      if (state_q != S_IDLE && ctrl_wr && cfg_wdata[3])
         abort_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (cfg_we) begin
               case (cfg_addr)
                  3'd0: src_d[7:0]         = cfg_wdata;
                  3'd1: src_d[15:8]        = cfg_wdata;
                  3'd2: src_d[ADDR_W-1:16] = cfg_wdata[ADDR_W-17:0];
                  3'd3: dst_d[7:0]         = cfg_wdata;
                  3'd4: dst_d[15:8]        = cfg_wdata;
                  3'd5: dst_d[ADDR_W-1:16] = cfg_wdata[ADDR_W-17:0];
                  3'd6: count_d            = cfg_wdata;
                  default: begin
                     if (cfg_wdata[0]) begin
                        state_d     = S_REQ;
                        src_mem_d   = cfg_wdata[1];
                        dst_mem_d   = cfg_wdata[2];
                        remaining_d = count_q;
                        abort_d     = 1'b0;
                     end
                  end
               endcase
            end
         end
         S_REQ: begin
            if (abort_q)      state_d = S_DONE;
            else if (dma_ack) state_d = S_RD;
         end
         S_RD: begin
            if (step) begin
               buf_d   = data_in;
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (step) begin
               src_d       = src_q + ADDR_ONE;
               dst_d       = dst_q + ADDR_ONE;
               remaining_d = remaining_q - 8'd1;
               state_d     = (remaining_q == 8'd1 || abort_q) ? S_DONE : S_RD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            abort_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // Set beats clear when both land in the DONE cycle.
      if (ctrl_wr && cfg_wdata[4]) irq_d = 1'b0;
      if (state_q == S_DONE)       irq_d = 1'b1;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         buf_q       <= '0;
         src_mem_q   <= 1'b0;
         dst_mem_q   <= 1'b0;
         abort_q     <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         buf_q       <= buf_d;
         src_mem_q   <= src_mem_d;
         dst_mem_q   <= dst_mem_d;
         abort_q     <= abort_d;
         irq_q       <= irq_d;
      end
   end

   // Bus outputs decode straight from state so reset releases the bus at once.
   assign rd_st       = (state_q == S_RD);
   assign wr_st       = (state_q == S_WR);
   assign dma_req     = (state_q == S_REQ) || rd_st || wr_st;
   assign bus_en      = rd_st || wr_st;
   assign rd_n        = !rd_st;
   assign wr_n        = !wr_st;
   assign data_oe     = wr_st;
   assign address_bus = rd_st ? src_q : (wr_st ? dst_q : '0);
   assign mem_io      = rd_st ? src_mem_q : (wr_st && dst_mem_q);
   assign data_out    = wr_st ? buf_q : 8'h00;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign irq         = irq_q;
   assign remaining   = remaining_q;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboarded bench for dma_controller: expected byte moves are queued at
// start and retired by a bus monitor on each completed read/write.
module tb_dma_controller;

   localparam int AW    = 22;
   localparam int LIMIT = 2000;

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [7:0]    data;
      logic          smem;
      logic          dmem;
   } xfer_t;

   logic          clk = 1'b0, arst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_addr = '0;
   logic [7:0]    cfg_wdata = '0;
   logic          dma_req, dma_ack = 1'b0, ext_wait = 1'b0;
   logic [AW-1:0] address_bus;
   logic          mem_io, rd_n, wr_n, data_oe, bus_en, busy, done, irq;
   logic [7:0]    data_in, data_out, remaining;

   int    checks = 0, errors = 0;
   xfer_t sb[$];

   dma_controller #(.ADDR_W(AW)) dut (
      .clk(clk), .arst(arst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .dma_req(dma_req), .dma_ack(dma_ack),
      .ext_wait(ext_wait), .address_bus(address_bus), .mem_io(mem_io),
      .rd_n(rd_n), .wr_n(wr_n), .data_in(data_in), .data_out(data_out),
      .data_oe(data_oe), .bus_en(bus_en), .busy(busy), .remaining(remaining),
      .done(done), .irq(irq)
   );

   always #5 clk = ~clk;

   // Memory model: each location reads back its low address byte ^ 5A.
   assign data_in = rd_n ? 8'h00 : (address_bus[7:0] ^ 8'h5A);

   always @(negedge clk) begin
      if (!arst) begin
         checks++;
         if (!rd_n && !wr_n) begin
            errors++;
            $display("FAIL strobe_overlap: rd_n=%b wr_n=%b, required not both low", rd_n, wr_n);
         end
         if (bus_en && dma_ack && !ext_wait) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_xfer: addr=%h rd_n=%b, required no bus cycle", address_bus, rd_n);
            end else if (!rd_n) begin
               if ({address_bus, mem_io} !== {sb[0].src, sb[0].smem}) begin
                  errors++;
                  $display("FAIL read_cycle: addr=%h mem_io=%b, required addr=%h mem_io=%b",
                           address_bus, mem_io, sb[0].src, sb[0].smem);
               end
            end else begin
               xfer_t e;
               e = sb.pop_front();
               if ({address_bus, mem_io, data_out, data_oe} !== {e.dst, e.dmem, e.data, 1'b1}) begin
                  errors++;
                  $display("FAIL write_cycle: addr=%h mem_io=%b data=%h oe=%b, required addr=%h mem_io=%b data=%h oe=1",
                           address_bus, mem_io, data_out, data_oe, e.dst, e.dmem, e.data);
               end
            end
         end
      end
   end

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic setup(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [7:0] n);
      cfg_write(3'd0, s[7:0]);
      cfg_write(3'd1, s[15:8]);
      cfg_write(3'd2, {2'b00, s[21:16]});
      cfg_write(3'd3, d[7:0]);
      cfg_write(3'd4, d[15:8]);
      cfg_write(3'd5, {2'b00, d[21:16]});
      cfg_write(3'd6, n);
   endtask

   task automatic push_exp(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                           input logic sm, input logic dm);
      xfer_t e;
      logic [AW-1:0] a, b;
      a = s; b = d;
      for (int i = 0; i < n; i++) begin
         e.src = a; e.dst = b; e.data = a[7:0] ^ 8'h5A; e.smem = sm; e.dmem = dm;
         sb.push_back(e);
         a = a + 22'd1; b = b + 22'd1;
      end
   endtask

   task automatic wait_done(output int ncyc, output int ndone);
      bit seen = 0;
      ncyc = -1; ndone = 0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (!seen) ncyc = i;
            seen = 1;
         end else if (seen && !busy) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({dma_req, bus_en, rd_n, wr_n, data_oe, mem_io, busy, done} !== 8'b0011_0000 ||
          address_bus !== '0 || data_out !== 8'h00 || remaining !== 8'h00) begin
         errors++;
         $display("FAIL %s: req=%b en=%b rd_n=%b wr_n=%b oe=%b mio=%b busy=%b done=%b addr=%h dout=%h rem=%0d, required reset values",
                  name, dma_req, bus_en, rd_n, wr_n, data_oe, mem_io, busy, done, address_bus, data_out, remaining);
      end
   endtask

   task automatic test_reset();
      #3;
      check_idle_outputs("reset_outputs");
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b, required 0", irq); end
      @(posedge clk); #1;
      arst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_copy();
      int nc, nd;
      setup(22'h000100, 22'h200000, 8'd3);
      push_exp(22'h000100, 22'h200000, 3, 1'b1, 1'b1);
      cfg_write(3'd7, 8'h07);
      @(negedge clk);
      checks++;
      if ({dma_req, busy, remaining} !== {1'b1, 1'b1, 8'd3}) begin
         errors++;
         $display("FAIL basic_req: req=%b busy=%b rem=%0d, required 1 1 3", dma_req, busy, remaining);
      end
      @(posedge clk); @(posedge clk); #1;
      dma_ack = 1'b1;
      wait_done(nc, nd);
      dma_ack = 1'b0;
      checks++;
      if (nd !== 1 || nc !== 7) begin
         errors++;
         $display("FAIL basic_done: pulses=%0d at_cycle=%0d, required 1 at 7", nd, nc);
      end
      checks++;
      if ({irq, remaining} !== {1'b1, 8'd0} || sb.size() != 0) begin
         errors++;
         $display("FAIL basic_final: irq=%b rem=%0d left=%0d, required 1 0 0", irq, remaining, sb.size());
      end
   endtask

   task automatic test_wrap();
      int nc, nd;
      setup(22'h3FFFFF, 22'h000010, 8'd2);
      push_exp(22'h3FFFFF, 22'h000010, 2, 1'b1, 1'b0);
      dma_ack = 1'b1;
      cfg_write(3'd7, 8'h03);
      wait_done(nc, nd);
      dma_ack = 1'b0;
      checks++;
      if (nd !== 1 || remaining !== 8'd0 || sb.size() != 0) begin
         errors++;
         $display("FAIL wrap_final: pulses=%0d rem=%0d left=%0d, required 1 0 0", nd, remaining, sb.size());
      end
   endtask

   task automatic test_wait_ack();
      int nc, nd;
      setup(22'h000040, 22'h000080, 8'd2);
      push_exp(22'h000040, 22'h000080, 2, 1'b1, 1'b1);
      dma_ack = 1'b1; ext_wait = 1'b1;
      cfg_write(3'd7, 8'h07);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({rd_n, wr_n, bus_en, address_bus, remaining} !== {1'b0, 1'b1, 1'b1, 22'h000040, 8'd2}) begin
            errors++;
            $display("FAIL wait_hold: rd_n=%b wr_n=%b en=%b addr=%h rem=%0d, required 0 1 1 000040 2",
                     rd_n, wr_n, bus_en, address_bus, remaining);
         end
      end
      ext_wait = 1'b0;
      @(posedge clk); #1;
      dma_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({wr_n, rd_n, data_oe, address_bus, data_out, remaining} !==
             {1'b0, 1'b1, 1'b1, 22'h000080, 8'h1A, 8'd2}) begin
            errors++;
            $display("FAIL ack_drop_hold: wr_n=%b rd_n=%b oe=%b addr=%h dout=%h rem=%0d, required 0 1 1 000080 1a 2",
                     wr_n, rd_n, data_oe, address_bus, data_out, remaining);
         end
         if (k < 2) begin @(posedge clk); #1; end
      end
      dma_ack = 1'b1;
      wait_done(nc, nd);
      dma_ack = 1'b0;
      checks++;
      if (nd !== 1 || remaining !== 8'd0 || sb.size() != 0) begin
         errors++;
         $display("FAIL wait_final: pulses=%0d rem=%0d left=%0d, required 1 0 0", nd, remaining, sb.size());
      end
   endtask

   task automatic test_abort();
      int nc, nd;
      setup(22'h001000, 22'h002000, 8'd0);
      push_exp(22'h001000, 22'h002000, 5, 1'b1, 1'b1);
      dma_ack = 1'b1;
      cfg_write(3'd7, 8'h07);
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if ({rd_n, address_bus} !== {1'b0, 22'h001004}) begin
         errors++;
         $display("FAIL abort_rd5: rd_n=%b addr=%h, required 0 001004", rd_n, address_bus);
      end
      cfg_write(3'd7, 8'h08);
      wait_done(nc, nd);
      dma_ack = 1'b0;
      checks++;
      if (nd !== 1 || remaining !== 8'd251 || sb.size() != 0) begin
         errors++;
         $display("FAIL abort_final: pulses=%0d rem=%0d left=%0d, required 1 251 0", nd, remaining, sb.size());
      end
   endtask

   task automatic test_irq_clear();
      cfg_write(3'd7, 8'h10);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_idle: irq=%b, required 0", irq); end
      setup(22'h000007, 22'h000008, 8'd1);
      push_exp(22'h000007, 22'h000008, 1, 1'b1, 1'b1);
      dma_ack = 1'b1;
      cfg_write(3'd7, 8'h07);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL irq_done_cycle: done=%b, required 1", done); end
      cfg_write(3'd7, 8'h10);
      dma_ack = 1'b0;
      checks++;
      if ({irq, done, busy} !== 3'b100 || sb.size() != 0) begin
         errors++;
         $display("FAIL irq_set_wins: irq=%b done=%b busy=%b left=%0d, required 1 0 0 0", irq, done, busy, sb.size());
      end
      cfg_write(3'd7, 8'h10);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_later_clear: irq=%b, required 0", irq); end
   endtask

   task automatic test_reset_mid();
      int nc, nd, pulses;
      setup(22'h000500, 22'h000600, 8'd4);
      push_exp(22'h000500, 22'h000600, 4, 1'b1, 1'b1);
      dma_ack = 1'b1;
      cfg_write(3'd7, 8'h07);
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (wr_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_wr: wr_n=%b, required 0", wr_n); end
      arst = 1'b1;
      #1;
      check_idle_outputs("rstmid_outputs");
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      arst = 1'b0; dma_ack = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checks++;
      if (pulses != 0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_done: pulses=%0d irq=%b, required 0 0", pulses, irq);
      end
      @(posedge clk); #1;
      setup(22'h000010, 22'h000020, 8'd1);
      push_exp(22'h000010, 22'h000020, 1, 1'b0, 1'b1);
      dma_ack = 1'b1;
      cfg_write(3'd7, 8'h05);
      wait_done(nc, nd);
      dma_ack = 1'b0;
      checks++;
      if (nd !== 1 || irq !== 1'b1 || remaining !== 8'd0 || sb.size() != 0) begin
         errors++;
         $display("FAIL rstmid_restart: pulses=%0d irq=%b rem=%0d left=%0d, required 1 1 0 0",
                  nd, irq, remaining, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_wrap();
      test_wait_ack();
      test_abort();
      test_irq_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
